// File: rtl/i2c_target_if.sv
// Signal bundle between an I2C target and its environment: raw pin levels, the
// open-drain SDA enable, and the byte-level write/read user interface.
interface i2c_target_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_first;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       start_det;
   logic       stop_det;
   logic       busy;

   modport slave (
      input  scl_in, sda_in, tx_data,
      output sda_oe, rx_data, rx_valid, rx_first, tx_req, start_det, stop_det, busy
   );

   modport master (
      output scl_in, sda_in, tx_data,
      input  sda_oe, rx_data, rx_valid, rx_first, tx_req, start_det, stop_det, busy
   );
endinterface

// File: rtl/i2c_target.sv
// Oversampling I2C target: START/STOP detection, 7-bit address match with ACK,
// byte-strobe write path and request-driven read path. Never drives SCL.
module i2c_target #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input  logic        clk,
   input  logic        rst_n,
   i2c_target_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAckA,
      StWr,
      StAckW,
      StRd,
      StAckR,
      StIgnore
   } state_e;

   // Synchronizers reset to the idle-bus level so reset release makes no false edge.
   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_hist_q, sda_hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], bus.scl_in};
         sda_sync_q <= {sda_sync_q[0], bus.sda_in};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
      end
   end

   logic scl_s, sda_s;
   logic scl_rise, scl_fall, sda_rise, sda_fall;
   logic start_c, stop_c;

   assign scl_s    = scl_sync_q[1];
   assign sda_s    = sda_sync_q[1];
   assign scl_rise = scl_s & ~scl_hist_q;
   assign scl_fall = ~scl_s & scl_hist_q;
   assign sda_rise = sda_s & ~sda_hist_q;
   assign sda_fall = ~sda_s & sda_hist_q;
   assign start_c  = sda_fall & scl_s;
   assign stop_c   = sda_rise & scl_s;

   state_e     state_q;
   logic [2:0] cnt_q;
   logic [7:0] shift_q;
   logic       rw_q;
   logic       ack_drv_q;
   logic       last_q;
   logic       first_q;
   logic       oe_tgt_q;
   logic       oe_upd_q;
   logic       sda_oe_q;
   logic [7:0] rx_data_q;
   logic       rx_valid_q;
   logic       rx_first_q;
   logic       tx_req_q;
   logic       start_q;
   logic       stop_q;
   logic       busy_q;

   // SDA changes are staged in oe_tgt_q on scl_fall and applied one cycle later,
   // giving extra hold time after SCL low; START/STOP/reset release SDA at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 3'd7;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         ack_drv_q  <= 1'b0;
         last_q     <= 1'b0;
         first_q    <= 1'b0;
         oe_tgt_q   <= 1'b0;
         oe_upd_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         rx_first_q <= 1'b0;
         tx_req_q   <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         oe_upd_q   <= 1'b0;
         if (oe_upd_q) sda_oe_q <= oe_tgt_q;
         // The user presents tx_data during the tx_req cycle.
         if (tx_req_q) shift_q <= bus.tx_data;

         if (stop_c) begin
            state_q  <= StIdle;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            stop_q   <= 1'b1;
         end else if (start_c) begin
            state_q  <= StAddr;
            cnt_q    <= 3'd7;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b1;
         end else begin
            case (state_q)
               StIdle: ;

               StAddr: begin
                  if (scl_rise) begin
                     shift_q <= {shift_q[6:0], sda_s};
                     cnt_q   <= cnt_q - 3'd1;
                     if (cnt_q == 3'd0) begin
                        if (shift_q[6:0] == ADDR) begin
                           state_q   <= StAckA;
                           rw_q      <= sda_s;
                           ack_drv_q <= 1'b0;
                        end else begin
                           state_q <= StIgnore;
                        end
                     end
                  end
               end

               // First fall drives the ACK; the ACK's trailing fall enters the data phase.
               StAckA: begin
                  if (scl_fall) begin
                     oe_upd_q <= 1'b1;
                     if (!ack_drv_q) begin
                        ack_drv_q <= 1'b1;
                        oe_tgt_q  <= 1'b1;
                        busy_q    <= 1'b1;
                     end else if (rw_q) begin
                        state_q  <= StRd;
                        oe_tgt_q <= ~shift_q[7];
                        shift_q  <= {shift_q[6:0], 1'b0};
                        cnt_q    <= 3'd6;
                        last_q   <= 1'b0;
                     end else begin
                        state_q  <= StWr;
                        oe_tgt_q <= 1'b0;
                        cnt_q    <= 3'd7;
                        last_q   <= 1'b0;
                        first_q  <= 1'b1;
                     end
                  end else if (scl_rise && ack_drv_q && rw_q) begin
                     tx_req_q <= 1'b1;
                  end
               end

               StWr: begin
                  if (scl_rise) begin
                     shift_q <= {shift_q[6:0], sda_s};
                     cnt_q   <= cnt_q - 3'd1;
                     if (cnt_q == 3'd0) begin
                        rx_data_q  <= {shift_q[6:0], sda_s};
                        rx_valid_q <= 1'b1;
                        rx_first_q <= first_q;
                        first_q    <= 1'b0;
                        last_q     <= 1'b1;
                     end
                  end else if (scl_fall && last_q) begin
                     state_q  <= StAckW;
                     oe_tgt_q <= 1'b1;
                     oe_upd_q <= 1'b1;
                     last_q   <= 1'b0;
                  end
               end

               StAckW: begin
                  if (scl_fall) begin
                     state_q  <= StWr;
                     oe_tgt_q <= 1'b0;
                     oe_upd_q <= 1'b1;
                     cnt_q    <= 3'd7;
                  end
               end

               StRd: begin
                  if (scl_fall) begin
                     oe_upd_q <= 1'b1;
                     if (last_q) begin
                        state_q  <= StAckR;
                        oe_tgt_q <= 1'b0;
                        last_q   <= 1'b0;
                     end else begin
                        oe_tgt_q <= ~shift_q[7];
                        shift_q  <= {shift_q[6:0], 1'b0};
                        cnt_q    <= cnt_q - 3'd1;
                        if (cnt_q == 3'd0) last_q <= 1'b1;
                     end
                  end
               end

               StAckR: begin
                  if (scl_rise) begin
                     if (!sda_s) begin
                        tx_req_q <= 1'b1;
                        state_q  <= StRd;
                        cnt_q    <= 3'd7;
                        last_q   <= 1'b0;
                     end else begin
                        state_q <= StIgnore;
                        busy_q  <= 1'b0;
                     end
                  end
               end

               StIgnore: ;

               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.sda_oe    = sda_oe_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.rx_first  = rx_first_q;
   assign bus.tx_req    = tx_req_q;
   assign bus.start_det = start_q;
   assign bus.stop_det  = stop_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level bus master drives SCL/SDA over a
// wired-AND SDA line while monitors count the target's strobes.
module tb_i2c_target;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] tx_val = 8'h00;

   int checks   = 0;
   int failures = 0;

   int rx_cnt     = 0;
   int tx_req_cnt = 0;
   int start_cnt  = 0;
   int stop_cnt   = 0;
   int oe_cnt     = 0;
   int busy_cnt   = 0;
   logic [7:0] rx_log_data  [0:31];
   logic       rx_log_first [0:31];

   i2c_target_if bus ();

   i2c_target #(.ADDR(7'h50)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.scl_in  = scl_m;
   assign bus.sda_in  = sda_m & ~bus.sda_oe;
   assign bus.tx_data = tx_val;

   always @(negedge clk) begin
      if (bus.rx_valid) begin
         rx_log_data[rx_cnt % 32]  <= bus.rx_data;
         rx_log_first[rx_cnt % 32] <= bus.rx_first;
         rx_cnt <= rx_cnt + 1;
      end
      if (bus.tx_req)    tx_req_cnt <= tx_req_cnt + 1;
      if (bus.start_det) start_cnt  <= start_cnt + 1;
      if (bus.stop_det)  stop_cnt   <= stop_cnt + 1;
      if (bus.sda_oe)    oe_cnt     <= oe_cnt + 1;
      if (bus.busy)      busy_cnt   <= busy_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      if (!scl_m) begin
         sda_m = 1'b1; tick(5);
         scl_m = 1'b1; tick(5);
      end
      sda_m = 1'b1; tick(5);
      sda_m = 1'b0; tick(10);
      scl_m = 1'b0; tick(5);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(5);
      scl_m = 1'b1; tick(10);
      sda_m = 1'b1; tick(10);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    tick(5);
      scl_m = 1'b1; tick(10);
      scl_m = 1'b0; tick(5);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      sda_m = 1'b1; tick(5);
      scl_m = 1'b1; tick(5);
      ack = bus.sda_in;
      tick(5);
      scl_m = 1'b0; tick(5);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         sda_m = 1'b1; tick(5);
         scl_m = 1'b1; tick(5);
         d[i] = bus.sda_in;
         tick(5);
         scl_m = 1'b0; tick(5);
      end
      sda_m = nack; tick(5);
      scl_m = 1'b1; tick(10);
      scl_m = 1'b0; tick(5);
   endtask

   task automatic test_reset();
      logic [6:0] flags;
      flags = {bus.sda_oe, bus.rx_valid, bus.rx_first, bus.tx_req,
               bus.start_det, bus.stop_det, bus.busy};
      checks++;
      if (flags !== 7'b0) begin
         failures++;
         $display("FAIL reset_flags_in_reset: got %b expected 0000000", flags);
      end
      rst_n = 1'b1;
      tick(5);
      flags = {bus.sda_oe, bus.rx_valid, bus.rx_first, bus.tx_req,
               bus.start_det, bus.stop_det, bus.busy};
      checks++;
      if (flags !== 7'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0000000", flags);
      end
      checks++;
      if (bus.rx_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data);
      end
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      int   rx0, st0, sp0;
      rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt;
      bus_start();
      write_byte(8'hA0, a0);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL wr_busy_after_ack: got %b expected 1", bus.busy);
      end
      write_byte(8'hA5, a1);
      write_byte(8'h3C, a2);
      bus_stop();
      checks++;
      if ({a0, a1, a2} !== 3'b000) begin
         failures++;
         $display("FAIL wr_acks: got %b expected 000", {a0, a1, a2});
      end
      checks++;
      if (rx_cnt - rx0 !== 2) begin
         failures++;
         $display("FAIL wr_rx_count: got %0d expected 2", rx_cnt - rx0);
      end
      checks++;
      if ({rx_log_first[rx0 % 32], rx_log_data[rx0 % 32]} !== {1'b1, 8'hA5}) begin
         failures++;
         $display("FAIL wr_byte0: got first=%b data=%h expected first=1 data=a5",
                  rx_log_first[rx0 % 32], rx_log_data[rx0 % 32]);
      end
      checks++;
      if ({rx_log_first[(rx0 + 1) % 32], rx_log_data[(rx0 + 1) % 32]} !== {1'b0, 8'h3C}) begin
         failures++;
         $display("FAIL wr_byte1: got first=%b data=%h expected first=0 data=3c",
                  rx_log_first[(rx0 + 1) % 32], rx_log_data[(rx0 + 1) % 32]);
      end
      checks++;
      if ((start_cnt - st0 !== 1) || (stop_cnt - sp0 !== 1)) begin
         failures++;
         $display("FAIL wr_start_stop: got start=%0d stop=%0d expected 1 1",
                  start_cnt - st0, stop_cnt - sp0);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL wr_busy_after_stop: got %b expected 0", bus.busy);
      end
   endtask

   task automatic test_mismatch();
      logic a0, a1;
      int   rx0, oe0, bz0, st0, sp0;
      rx0 = rx_cnt; oe0 = oe_cnt; bz0 = busy_cnt; st0 = start_cnt; sp0 = stop_cnt;
      bus_start();
      write_byte(8'hA2, a0);
      write_byte(8'h55, a1);
      bus_stop();
      checks++;
      if ({a0, a1} !== 2'b11) begin
         failures++;
         $display("FAIL mm_nack: got %b expected 11", {a0, a1});
      end
      checks++;
      if (oe_cnt - oe0 !== 0) begin
         failures++;
         $display("FAIL mm_sda_oe: got %0d driven cycles expected 0", oe_cnt - oe0);
      end
      checks++;
      if ((rx_cnt - rx0 !== 0) || (busy_cnt - bz0 !== 0)) begin
         failures++;
         $display("FAIL mm_rx_busy: got rx=%0d busy=%0d expected 0 0",
                  rx_cnt - rx0, busy_cnt - bz0);
      end
      checks++;
      if ((start_cnt - st0 !== 1) || (stop_cnt - sp0 !== 1)) begin
         failures++;
         $display("FAIL mm_start_stop: got start=%0d stop=%0d expected 1 1",
                  start_cnt - st0, stop_cnt - sp0);
      end
   endtask

   task automatic test_read();
      logic       a0;
      logic [7:0] d0, d1;
      int         tq0;
      tq0 = tx_req_cnt;
      tx_val = 8'h3C;
      bus_start();
      write_byte(8'hA1, a0);
      tx_val = 8'hC3;
      read_byte(1'b0, d0);
      read_byte(1'b1, d1);
      tick(20);
      checks++;
      if (a0 !== 1'b0) begin
         failures++;
         $display("FAIL rd_addr_ack: got %b expected 0", a0);
      end
      checks++;
      if (d0 !== 8'h3C) begin
         failures++;
         $display("FAIL rd_byte0: got %h expected 3c", d0);
      end
      checks++;
      if (d1 !== 8'hC3) begin
         failures++;
         $display("FAIL rd_byte1: got %h expected c3", d1);
      end
      checks++;
      if (tx_req_cnt - tq0 !== 2) begin
         failures++;
         $display("FAIL rd_tx_req_count: got %0d expected 2", tx_req_cnt - tq0);
      end
      checks++;
      if ({bus.sda_oe, bus.busy} !== 2'b00) begin
         failures++;
         $display("FAIL rd_after_nack: got oe=%b busy=%b expected 0 0", bus.sda_oe, bus.busy);
      end
      bus_stop();
   endtask

   task automatic test_rep_start();
      logic       a0, a1, a2;
      logic [7:0] d0;
      int         rx0, st0;
      rx0 = rx_cnt; st0 = start_cnt;
      bus_start();
      write_byte(8'hA0, a0);
      write_byte(8'h11, a1);
      tx_val = 8'h5A;
      bus_start();
      write_byte(8'hA1, a2);
      read_byte(1'b1, d0);
      bus_stop();
      checks++;
      if ({a0, a1, a2} !== 3'b000) begin
         failures++;
         $display("FAIL rs_acks: got %b expected 000", {a0, a1, a2});
      end
      checks++;
      if ((rx_cnt - rx0 !== 1) || (rx_log_data[rx0 % 32] !== 8'h11) ||
          (rx_log_first[rx0 % 32] !== 1'b1)) begin
         failures++;
         $display("FAIL rs_rx: got count=%0d data=%h first=%b expected 1 11 1",
                  rx_cnt - rx0, rx_log_data[rx0 % 32], rx_log_first[rx0 % 32]);
      end
      checks++;
      if (start_cnt - st0 !== 2) begin
         failures++;
         $display("FAIL rs_start_count: got %0d expected 2", start_cnt - st0);
      end
      checks++;
      if (d0 !== 8'h5A) begin
         failures++;
         $display("FAIL rs_read_byte: got %h expected 5a", d0);
      end
   endtask

   task automatic test_mid_stop();
      logic a0, a1;
      int   rx0, sp0;
      rx0 = rx_cnt; sp0 = stop_cnt;
      bus_start();
      write_byte(8'hA0, a0);
      write_bit(1'b1);
      write_bit(1'b0);
      write_bit(1'b1);
      write_bit(1'b0);
      bus_stop();
      checks++;
      if ((rx_cnt - rx0 !== 0) || (stop_cnt - sp0 !== 1)) begin
         failures++;
         $display("FAIL ms_partial: got rx=%0d stop=%0d expected 0 1", rx_cnt - rx0, stop_cnt - sp0);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL ms_busy: got %b expected 0", bus.busy);
      end
      rx0 = rx_cnt;
      bus_start();
      write_byte(8'hA0, a0);
      write_byte(8'h77, a1);
      bus_stop();
      checks++;
      if ((rx_cnt - rx0 !== 1) || (bus.rx_data !== 8'h77) || ({a0, a1} !== 2'b00)) begin
         failures++;
         $display("FAIL ms_next_txn: got count=%0d data=%h acks=%b expected 1 77 00",
                  rx_cnt - rx0, bus.rx_data, {a0, a1});
      end
   endtask

   task automatic test_reset_during_ack();
      logic [6:0] flags;
      bus_start();
      for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
      sda_m = 1'b1;
      checks++;
      if (bus.sda_oe !== 1'b1) begin
         failures++;
         $display("FAIL ra_ack_driven: got %b expected 1", bus.sda_oe);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.sda_oe !== 1'b0) begin
         failures++;
         $display("FAIL ra_async_release: got %b expected 0", bus.sda_oe);
      end
      flags = {bus.sda_oe, bus.rx_valid, bus.rx_first, bus.tx_req,
               bus.start_det, bus.stop_det, bus.busy};
      checks++;
      if ((flags !== 7'b0) || (bus.rx_data !== 8'h00)) begin
         failures++;
         $display("FAIL ra_reset_values: got flags=%b rx_data=%h expected 0000000 00",
                  flags, bus.rx_data);
      end
      tick(3);
      rst_n = 1'b1;
      tick(3);
      bus_stop();
   endtask

   initial begin
      tick(4);
      test_reset();
      tick(10);
      test_write();
      test_mismatch();
      test_read();
      test_rep_start();
      test_mid_stop();
      test_reset_during_ack();
      tick(10);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
